// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the PWM bank: reset defaults of a channel
// configuration entry and the channel-select width derivation.
package pwm_pkg;

  // Reset value of every shadow and active configuration entry.
  localparam logic RST_ON   = 1'b0;
  localparam logic RST_OFF  = 1'b1;
  localparam int   RST_HIGH = 0;
  localparam int   RST_LOW  = 0;

  // Width of a channel index; a single-channel bank still gets one select bit.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_bank_if.sv
// Configuration write port of the PWM bank: valid/ready handshake carrying one
// channel entry {on, off, high, low} per accepted beat.
interface pwm_bank_if #(
  parameter int CHAN_W = 4,
  parameter int WIDTH  = 12
);
  logic              wr_valid;
  logic              wr_ready;
  logic [CHAN_W-1:0] wr_chan;
  logic              wr_on;
  logic              wr_off;
  logic [WIDTH-1:0]  wr_high;
  logic [WIDTH-1:0]  wr_low;

  modport master (
    output wr_valid, wr_chan, wr_on, wr_off, wr_high, wr_low,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_chan, wr_on, wr_off, wr_high, wr_low,
    output wr_ready
  );
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered configuration (shadow/active), commit
// control, on/off/window compare against the shared counter, registered level.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sleep_i,
  input  logic             update_mode_i,
  input  logic             wrap_i,
  input  logic             wr_en_i,
  input  logic             wr_on_i,
  input  logic             wr_off_i,
  input  logic [WIDTH-1:0] wr_high_i,
  input  logic [WIDTH-1:0] wr_low_i,
  input  logic [WIDTH-1:0] counter_i,
  output logic             raw_o
);

  typedef struct packed {
    logic             on;
    logic             off;
    logic [WIDTH-1:0] high;
    logic [WIDTH-1:0] low;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    on:   RST_ON,
    off:  RST_OFF,
    high: WIDTH'(RST_HIGH),
    low:  WIDTH'(RST_LOW)
  };

  cfg_t shadow_q, shadow_d;
  cfg_t active_q, active_d;
  cfg_t wr_cfg;
  logic raw_q, raw_d;

  assign wr_cfg = '{on: wr_on_i, off: wr_off_i, high: wr_high_i, low: wr_low_i};

  // A wrap-cycle write lands in shadow only: active takes the pre-write shadow.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en_i) begin
      shadow_d = wr_cfg;
    end
    if (wr_en_i && update_mode_i) begin
      active_d = wr_cfg;
    end else if (wrap_i && !update_mode_i) begin
      active_d = shadow_q;
    end
  end

  always_comb begin
    raw_d = 1'b0;
    if (sleep_i || active_q.off) begin
      raw_d = 1'b0;
    end else if (active_q.on) begin
      raw_d = 1'b1;
    end else if (active_q.high < active_q.low) begin
      raw_d = (counter_i >= active_q.high) && (counter_i < active_q.low);
    end else if (active_q.high > active_q.low) begin
      // Window spans the period wrap.
      raw_d = (counter_i >= active_q.high) || (counter_i < active_q.low);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= CFG_RST;
      active_q <= CFG_RST;
      raw_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      raw_q    <= raw_d;
    end
  end

  assign raw_o = raw_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: shared prescaler and period counter, write
// decode to per-channel configuration, period-start pulse, output polarity.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int CHANNELS       = 16,
  parameter int WIDTH          = 12,
  parameter int PRESCALE_WIDTH = 8,
  parameter int CHAN_W         = chan_w(CHANNELS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic                      sleep_i,
  input  logic                      invert_i,
  input  logic                      update_mode_i,
  pwm_bank_if.slave                 wr,
  output logic [CHANNELS-1:0]       pwm_o,
  output logic [WIDTH-1:0]          counter_o,
  output logic                      period_start_o
);

  logic [PRESCALE_WIDTH-1:0] prescaler_q, prescaler_d;
  logic [WIDTH-1:0]          counter_q, counter_d;
  logic                      period_start_q, period_start_d;
  logic                      tick;
  logic                      wrap;
  logic                      accept;
  logic [CHANNELS-1:0]       wr_en;
  logic [CHANNELS-1:0]       raw;

  // '>=' rather than '==' so lowering prescale_i mid-count cannot stall.
  always_comb begin
    tick        = 1'b0;
    prescaler_d = prescaler_q;
    counter_d   = counter_q;
    if (sleep_i) begin
      prescaler_d = '0;
      counter_d   = '0;
    end else if (prescaler_q >= prescale_i) begin
      tick        = 1'b1;
      prescaler_d = '0;
      counter_d   = counter_q + WIDTH'(1);
    end else begin
      prescaler_d = prescaler_q + PRESCALE_WIDTH'(1);
    end
  end

  assign wrap = tick && (&counter_q);

  // First clock of count 0 is the one where the prescaler has just cleared.
  assign period_start_d = !sleep_i && (counter_q == '0) && (prescaler_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prescaler_q    <= '0;
      counter_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      prescaler_q    <= prescaler_d;
      counter_q      <= counter_d;
      period_start_q <= period_start_d;
    end
  end

  assign wr.wr_ready = !rst_i;
  assign accept      = wr.wr_valid && wr.wr_ready;

  // Channel indices at or above CHANNELS match no decoder and are dropped.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign wr_en[gi] = accept && (wr.wr_chan == CHAN_W'(gi));

      pwm_channel #(
        .WIDTH (WIDTH)
      ) u_channel (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sleep_i       (sleep_i),
        .update_mode_i (update_mode_i),
        .wrap_i        (wrap),
        .wr_en_i       (wr_en[gi]),
        .wr_on_i       (wr.wr_on),
        .wr_off_i      (wr.wr_off),
        .wr_high_i     (wr.wr_high),
        .wr_low_i      (wr.wr_low),
        .counter_i     (counter_q),
        .raw_o         (raw[gi])
      );
    end
  endgenerate

  assign pwm_o          = raw ^ {CHANNELS{invert_i}};
  assign counter_o      = counter_q;
  assign period_start_o = period_start_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: table of single-sample window checks plus
// hand-written sequences for commit timing, wrap windows, sleep and reset.
module tb_pwm_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  prescale = 8'd0;
  logic        sleep = 1'b0;
  logic        invert = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] pwm;
  logic [11:0] counter;
  logic        ps;
  logic [19:0] pwm2;
  logic [11:0] counter2;
  logic        ps2;

  int n_cmp = 0;
  int n_bad = 0;

  pwm_bank_if #(.CHAN_W(4), .WIDTH(12)) wr1 ();
  pwm_bank_if #(.CHAN_W(5), .WIDTH(12)) wr2 ();

  pwm_bank #(.CHANNELS(16), .WIDTH(12), .PRESCALE_WIDTH(8)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .prescale_i     (prescale),
    .sleep_i        (sleep),
    .invert_i       (invert),
    .update_mode_i  (mode),
    .wr             (wr1),
    .pwm_o          (pwm),
    .counter_o      (counter),
    .period_start_o (ps)
  );

  pwm_bank #(.CHANNELS(20), .WIDTH(12), .PRESCALE_WIDTH(8)) dut20 (
    .clk_i          (clk),
    .rst_i          (rst),
    .prescale_i     (prescale),
    .sleep_i        (1'b0),
    .invert_i       (1'b0),
    .update_mode_i  (1'b1),
    .wr             (wr2),
    .pwm_o          (pwm2),
    .counter_o      (counter2),
    .period_start_o (ps2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          chan;
    bit          on;
    bit          off;
    logic [11:0] high;
    logic [11:0] low;
    logic [11:0] cnt;
    bit          exp;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cnt(input logic [11:0] val, input int budget);
    int k;
    k = 0;
    while (counter !== val && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (counter !== val) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_cnt: counter %0h never reached %0h", counter, val);
    end
  endtask

  task automatic do_write(input int ch, input bit on, input bit off,
                          input logic [11:0] high, input logic [11:0] low);
    $display("wr ch%0d on=%0b off=%0b high=%03h low=%03h at cnt=%03h mode=%0b",
             ch, on, off, high, low, counter, mode);
    wr1.wr_chan  = 4'(ch);
    wr1.wr_on    = on;
    wr1.wr_off   = off;
    wr1.wr_high  = high;
    wr1.wr_low   = low;
    wr1.wr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr1.wr_valid = 1'b0;
  endtask

  initial begin
    int h3, h5, fc3, nps, psc, k;
    bit b5_first;

    vecs[0]  = '{1, 1'b0, 1'b0, 12'h040, 12'h080, 12'h020, 1'b0};
    vecs[1]  = '{1, 1'b0, 1'b0, 12'h040, 12'h080, 12'h040, 1'b1};
    vecs[2]  = '{1, 1'b0, 1'b0, 12'h040, 12'h080, 12'h07F, 1'b1};
    vecs[3]  = '{1, 1'b0, 1'b0, 12'h040, 12'h080, 12'h080, 1'b0};
    vecs[4]  = '{2, 1'b0, 1'b0, 12'h0C0, 12'h0A0, 12'h0A0, 1'b0};
    vecs[5]  = '{2, 1'b0, 1'b0, 12'h0C0, 12'h0A0, 12'h0B0, 1'b0};
    vecs[6]  = '{2, 1'b0, 1'b0, 12'h0C0, 12'h0A0, 12'h0C0, 1'b1};
    vecs[7]  = '{2, 1'b0, 1'b0, 12'h800, 12'h100, 12'h0F0, 1'b1};
    vecs[8]  = '{7, 1'b0, 1'b0, 12'h200, 12'h200, 12'h200, 1'b0};
    vecs[9]  = '{7, 1'b1, 1'b0, 12'h200, 12'h200, 12'h210, 1'b1};
    vecs[10] = '{7, 1'b1, 1'b1, 12'h200, 12'h200, 12'h220, 1'b0};
    vecs[11] = '{7, 1'b0, 1'b0, 12'h000, 12'hFFF, 12'h230, 1'b1};
    vecs[12] = '{7, 1'b0, 1'b0, 12'h300, 12'h240, 12'h240, 1'b0};
    vecs[13] = '{6, 1'b0, 1'b0, 12'hFFF, 12'h000, 12'h800, 1'b0};
    vecs[14] = '{6, 1'b0, 1'b0, 12'hFFF, 12'h000, 12'hFFF, 1'b1};

    wr1.wr_valid = 1'b0; wr1.wr_chan = '0; wr1.wr_on = 1'b0; wr1.wr_off = 1'b0;
    wr1.wr_high = '0; wr1.wr_low = '0;
    wr2.wr_valid = 1'b0; wr2.wr_chan = '0; wr2.wr_on = 1'b0; wr2.wr_off = 1'b0;
    wr2.wr_high = '0; wr2.wr_low = '0;

    // Reset state, both polarities.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_counter", 64'(counter), 64'h0);
    check("rst_pwm", 64'(pwm), 64'h0);
    check("rst_ready", 64'(wr1.wr_ready), 64'h1);
    check("rst_period_start", 64'(ps), 64'h0);
    check("rst_counter20", 64'(counter2), 64'h0);
    check("rst_ps20", 64'(ps2), 64'h0);
    check("rst_pwm20", 64'(pwm2), 64'h0);
    invert = 1'b1;
    #1;
    check("rst_pwm_inverted", 64'(pwm), 64'hFFFF);
    invert = 1'b0;
    #1;

    // 20-channel bank: index 20 is dropped, index 19 lands.
    check("ready20", 64'(wr2.wr_ready), 64'h1);
    $display("wr20 ch20 on=1 off=0");
    wr2.wr_chan = 5'd20; wr2.wr_on = 1'b1; wr2.wr_off = 1'b0; wr2.wr_valid = 1'b1;
    @(negedge clk);
    wr2.wr_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("ch20_discarded", 64'(pwm2), 64'h0);
    $display("wr20 ch19 on=1 off=0");
    wr2.wr_chan = 5'd19; wr2.wr_valid = 1'b1;
    @(negedge clk);
    wr2.wr_valid = 1'b0;
    @(negedge clk);
    check("ch19_on", 64'(pwm2), 64'h80000);

    // Wrap-commit mode: nothing visible until the period wraps.
    mode = 1'b0;
    do_write(3, 1'b0, 1'b0, 12'h100, 12'h200);
    do_write(5, 1'b0, 1'b0, 12'hF00, 12'h100);
    h3 = 0; k = 0;
    while (counter != 12'h000 && k < 5000) begin
      @(negedge clk);
      if (pwm[3]) h3++;
      k++;
    end
    check("p0_reached_wrap", 64'(counter), 64'h0);
    check("p0_ch3_no_change", 64'(h3), 64'h0);

    wait_cnt(12'h001, 10);
    h3 = 0; h5 = 0; fc3 = -1; nps = 0; psc = -1;
    b5_first = pwm[5];
    for (int i = 0; i < 4096; i++) begin
      if (pwm[3]) begin
        if (h3 == 0) fc3 = int'(counter);
        h3++;
      end
      if (pwm[5]) h5++;
      if (ps) begin
        nps++;
        psc = int'(counter);
      end
      @(negedge clk);
    end
    $display("period: ch3 high=%0d first=%03h ch5 high=%0d ps=%0d", h3, fc3, h5, nps);
    check("ch3_high_clocks", 64'(h3), 64'd256);
    check("ch3_rise_point", 64'(fc3), 64'h101);
    check("ch5_wrap_high_clocks", 64'(h5), 64'd512);
    check("ch5_active_at_count0", 64'(b5_first), 64'h1);
    check("period_start_count", 64'(nps), 64'd1);
    check("period_start_align", 64'(psc), 64'h1);

    // Write during the wrap cycle waits a further period.
    wait_cnt(12'hFFF, 4200);
    do_write(3, 1'b0, 1'b1, 12'h100, 12'h200);
    wait_cnt(12'h150, 4200);
    check("wrap_write_deferred", 64'(pwm[3]), 64'h1);
    @(negedge clk);
    wait_cnt(12'h150, 4200);
    check("wrap_write_applied", 64'(pwm[3]), 64'h0);

    // Immediate mode: new window visible two clocks after the accept.
    mode = 1'b1;
    wait_cnt(12'h400, 4200);
    do_write(0, 1'b0, 1'b0, 12'h000, 12'h800);
    check("imm_one_clock", 64'(pwm[0]), 64'h0);
    @(negedge clk);
    check("imm_two_clocks", 64'(pwm[0]), 64'h1);

    // Table of single-sample window and priority checks.
    wait_cnt(12'h005, 4200);
    for (int i = 0; i < 15; i++) begin
      do_write(vecs[i].chan, vecs[i].on, vecs[i].off, vecs[i].high, vecs[i].low);
      wait_cnt(vecs[i].cnt + 12'd1, 4200);
      $display("vec %0d ch%0d count=%03h pwm=%0b", i, vecs[i].chan, vecs[i].cnt, pwm[vecs[i].chan]);
      check($sformatf("vec%0d", i), 64'(pwm[vecs[i].chan]), 64'(vecs[i].exp));
    end

    // Prescale 3, sleep, resume from 0.
    prescale = 8'd3;
    sleep = 1'b1;
    @(negedge clk);
    check("sleep_counter", 64'(counter), 64'h0);
    check("sleep_pwm", 64'(pwm), 64'h0);
    sleep = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check($sformatf("prescale_step%0d", i), 64'(counter), 64'(i / 4));
    end
    wait_cnt(12'h123, 5000);
    check("ch0_active_at_123", 64'(pwm[0]), 64'h1);
    sleep = 1'b1;
    @(negedge clk);
    check("sleep_at_123_counter", 64'(counter), 64'h0);
    check("sleep_at_123_pwm", 64'(pwm), 64'h0);
    @(negedge clk);
    check("sleep_held", 64'(counter), 64'h0);
    sleep = 1'b0;
    repeat (4) @(negedge clk);
    check("wake_first_step", 64'(counter), 64'h1);

    // Reset in the middle of a period.
    wait_cnt(12'h010, 500);
    check("pre_reset_ch0", 64'(pwm[0]), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_counter", 64'(counter), 64'h0);
    check("midrst_pwm", 64'(pwm), 64'h0);
    check("midrst_ps", 64'(ps), 64'h0);
    check("midrst_ready", 64'(wr1.wr_ready), 64'h0);
    rst = 1'b0;
    prescale = 8'd0;
    #1;
    check("postrst_ready", 64'(wr1.wr_ready), 64'h1);
    repeat (3) @(negedge clk);
    check("postrst_counter", 64'(counter), 64'h3);
    check("postrst_cfg_cleared", 64'(pwm), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
